// File: rtl/filter_pad_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : filter_pad_sequencer_pkg
// Description : Shared types and helpers for the filter pad sequencer:
//               pixel width, FSM state encoding and pad-position decode.
// Revision    : 1.0 - initial release
// ============================================================================
package filter_pad_sequencer_pkg;

  localparam int c_PIX_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when (row, col) lies in the zero border around the active image.
  function automatic logic pad_position(input logic [31:0] row,
                                        input logic [31:0] col,
                                        input logic [31:0] width,
                                        input logic [31:0] height,
                                        input logic [31:0] b);
    return (row < b) || (row >= height + b) || (col < b) || (col >= width + b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/filter_pad_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : filter_pad_sequencer_if
// Description : Pixel stream bundle: upstream valid/ready pixel input and
//               the filter-side clock-enable/data/output-valid signals.
//               'master' is the sequencer side, 'slave' the environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface filter_pad_sequencer_if
  import filter_pad_sequencer_pkg::*;
  ;
  logic                   iPixValid;
  logic [c_PIX_WIDTH-1:0] iPixData;
  logic                   oPixReady;
  logic                   oFiltValid;
  logic [c_PIX_WIDTH-1:0] oFiltData;
  logic                   iFiltValid;

  modport master (
    input  iPixValid, iPixData, iFiltValid,
    output oPixReady, oFiltValid, oFiltData
  );

  modport slave (
    output iPixValid, iPixData, iFiltValid,
    input  oPixReady, oFiltValid, oFiltData
  );
endinterface
`default_nettype wire

// File: rtl/filter_pad_sequencer_pad_position_counter.sv
`default_nettype none
// ============================================================================
// Module      : filter_pad_sequencer_pad_position_counter
// Description : Column/row position counters over the padded frame. Wraps
//               col into row, and row back to 0 after the final position so
//               the counters are at the origin for the next frame.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_pad_sequencer_pad_position_counter
  import filter_pad_sequencer_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int B      = 1
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic adv,
  output logic      is_pad,
  output logic      is_last
);

  localparam int c_ROW_LEN = WIDTH + 2 * B;
  localparam int c_NROWS   = HEIGHT + 2 * B;
  localparam int c_CW      = $clog2(c_ROW_LEN);
  localparam int c_RW      = $clog2(c_NROWS);
  localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(c_ROW_LEN - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(c_NROWS - 1);

  logic [c_CW-1:0] r_col;
  logic [c_RW-1:0] r_row;

  // Advance one position per emitted pixel; col wraps into row, row wraps to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (adv) begin
      if (r_col == c_COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign is_pad  = pad_position(32'(r_row), 32'(r_col), 32'(WIDTH),
                                32'(HEIGHT), 32'(B));
  assign is_last = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

endmodule
`default_nettype wire

// File: rtl/filter_pad_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : filter_pad_sequencer
// Description : Feeds a row-buffered convolution filter: forwards upstream
//               pixels, inserts the zero border, drains the filter pipeline
//               with trailing zeros, and checks the filter's output count.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_pad_sequencer
  import filter_pad_sequencer_pkg::*;
#(
  parameter int WIDTH        = 320,
  parameter int HEIGHT       = 240,
  parameter int KERNEL_SIZE  = 3,
  parameter int DRAIN_CYCLES = 333
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              iStart,
  filter_pad_sequencer_if.master bus,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oError
);

  localparam int c_B  = (KERNEL_SIZE - 1) / 2;
  localparam int c_DW = $clog2(DRAIN_CYCLES + 1);
  localparam int c_OW = $clog2(WIDTH * HEIGHT + 1);
  localparam logic [c_DW-1:0] c_DRAIN_N    = c_DW'(DRAIN_CYCLES);
  localparam logic [c_OW-1:0] c_OUT_TARGET = c_OW'(WIDTH * HEIGHT);
  localparam logic [c_OW-1:0] c_OUT_MAX    = '1;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_is_pad;
  logic                   w_is_last;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_adv;
  logic                   w_emit_drain;
  logic [c_DW-1:0]        r_drain_cnt;
  logic [c_OW-1:0]        r_out_cnt;
  logic [c_OW-1:0]        w_out_cnt_next;
  logic                   r_filt_valid;
  logic [c_PIX_WIDTH-1:0] r_filt_data;
  logic                   r_error;

  filter_pad_sequencer_pad_position_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .B      (c_B)
  ) u_pos (
    .clk     (clk),
    .reset   (reset),
    .adv     (w_adv),
    .is_pad  (w_is_pad),
    .is_last (w_is_last)
  );

  // Next-state and per-cycle emit decode. Accepting iStart already emits
  // position (0,0), which is always a pad, so the first zero is visible in
  // the cycle after the start.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_accept     = 1'b0;
    w_adv        = 1'b0;
    w_emit_drain = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          w_adv        = 1'b1;
          w_state_next = ST_FRAME;
        end
      end
      ST_FRAME: begin
        w_ready  = !w_is_pad;
        w_accept = w_ready && bus.iPixValid;
        w_adv    = w_is_pad || w_accept;
        if (w_adv && w_is_last) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // One extra non-emitting cycle after the last zero so oDone lands
        // one cycle after that zero is visible.
        if (r_drain_cnt == c_DRAIN_N) w_state_next = ST_DONE;
        else                          w_emit_drain = 1'b1;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Saturating count of filter outputs seen while busy.
  always_comb begin
    w_out_cnt_next = r_out_cnt;
    if ((r_state != ST_IDLE) && bus.iFiltValid && (r_out_cnt != c_OUT_MAX))
      w_out_cnt_next = r_out_cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Registered filter outputs, drain/output counters and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt_valid <= 1'b0;
      r_filt_data  <= '0;
      r_drain_cnt  <= '0;
      r_out_cnt    <= '0;
      r_error      <= 1'b0;
    end else begin
      r_filt_valid <= w_adv || w_emit_drain;
      r_filt_data  <= w_accept ? bus.iPixData : '0;
      r_drain_cnt  <= w_emit_drain ? r_drain_cnt + 1'b1 : '0;
      r_out_cnt    <= (r_state == ST_DONE) ? '0 : w_out_cnt_next;
      if ((r_state == ST_IDLE) && iStart)
        r_error <= 1'b0;
      else if ((r_state == ST_DRAIN) && (w_state_next == ST_DONE))
        r_error <= (w_out_cnt_next != c_OUT_TARGET);
    end
  end

  assign bus.oPixReady  = w_ready;
  assign bus.oFiltValid = r_filt_valid;
  assign bus.oFiltData  = r_filt_data;
  assign oBusy          = (r_state != ST_IDLE);
  assign oDone          = (r_state == ST_DONE);
  assign oError         = r_error;

endmodule
`default_nettype wire

// File: doc/filter_pad_sequencer.md
# filter_pad_sequencer

Frame sequencer placed in front of the row-buffered convolution filters (3x3 / 7x7 FIFO filters). It accepts a raster stream of active pixels from upstream with a valid/ready handshake, inserts the zero boundary rows and columns the filter expects, and keeps the filter's clock-enable running after the last row so its pipeline drains. It counts valid filter outputs and reports frame completion or a count mismatch.

## Interface

Parameters:
- WIDTH, 320, active pixels per row
- HEIGHT, 240, active rows per frame
- KERNEL_SIZE, 3, odd, 3..7; B = (KERNEL_SIZE-1)/2
- DRAIN_CYCLES, 333, zero pixels pushed after the last padded row (one padded row + filter latency)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- iStart  in  1  start one frame; sampled only in IDLE
- iPixValid  in  1  upstream pixel valid
- iPixData  in  24  upstream pixel {r,g,b}
- oPixReady  out  1  upstream ready; decoded from registered state only
- oFiltValid  out  1  filter iValid (clock-enable)
- oFiltData  out  24  filter iData
- iFiltValid  in  1  filter oValid
- oBusy  out  1  high from start accept until DONE exit
- oDone  out  1  one-cycle pulse at frame end
- oError  out  1  sticky; output count != WIDTH*HEIGHT at frame end; cleared by the next accepted iStart

## Operation

- Padded frame: ROW_LEN = WIDTH+2B columns, NROWS = HEIGHT+2B rows; col counter 0..ROW_LEN-1, row counter 0..NROWS-1, wrap col→0 and increment row.
- Pad position: row<B, row≥HEIGHT+B, col<B or col≥WIDTH+B. A pad position emits 0 every cycle unconditionally.
- Active position: oPixReady=1; on iPixValid&&oPixReady the pixel is forwarded and the counters advance; with no handshake oFiltValid=0 (filter stalls) and the counters hold.
- States: IDLE → (iStart) FRAME → (last pixel at row NROWS-1, col ROW_LEN-1) DRAIN → (DRAIN_CYCLES zeros emitted) DONE → IDLE.
- DRAIN: oFiltValid=1 with data 0 on every cycle.
- Output counter (width ⌈log2(WIDTH*HEIGHT+1)⌉, saturating) increments on iFiltValid while oBusy.
- DONE: oDone=1 for that cycle. oError is set if the count ≠ WIDTH*HEIGHT. Counters clear on return to IDLE.
- iStart outside IDLE is ignored. iPixValid outside an active position is ignored; oPixReady is 0 there.

## Timing

- Reset values: oPixReady=0, oFiltValid=0, oFiltData=0, oBusy=0, oDone=0, oError=0, state IDLE, all counters 0.
- oFiltValid/oFiltData are registered: an accept or pad position in cycle n appears on the outputs in cycle n+1.
- iStart in cycle n: oBusy=1 in n+1, first pad pixel on oFiltValid in n+1 (B>0 always).
- Frame with no upstream stalls: exactly ROW_LEN*NROWS + DRAIN_CYCLES oFiltValid cycles. oDone occurs in the cycle after the last drain pixel is visible on the outputs; oBusy falls in the cycle after oDone.
- Stalls only extend FRAME; pad positions never stall.
- reset asserted mid-frame: all outputs return to reset values immediately, and the partial frame is discarded. After release, the block waits in IDLE for a new iStart.
- iStart coincident with oDone: ignored (state is DONE, not IDLE).

## Structure

- Shared package: pixel width (24), state encoding (IDLE/FRAME/DRAIN/DONE), pad/active position decode function of (row, col, WIDTH, HEIGHT, B).
- One sub-module is natural: pad_position_counter (col/row counters with wrap, emitting is_pad, is_last). The FSM, drain counter and output counter stay in the top level.

## Test plan

- WIDTH=4, HEIGHT=2, K=3, DRAIN_CYCLES=10, iPixValid held 1, iStart pulse → 24 padded + 10 drain oFiltValid cycles. Data sequence: row 0 = six zeros; row 1 = 0,p0..p3,0; row 3 = zeros.
- Same configuration, iPixValid toggled 1,0 every cycle → identical oFiltData sequence. oFiltValid gaps occur only at active positions; oPixReady=0 on every pad cycle.
- Filter model returns exactly 8 iFiltValid pulses → oDone pulse, oError=0. Returning 7 pulses → oError=1, held until the next iStart.
- iStart reasserted during FRAME and coincident with oDone → no effect. A later iStart in IDLE clears oError and starts a fresh frame.
- reset driven low mid-row 1 → next cycle oFiltValid=0, oBusy=0, oPixReady=0. After release and iStart, the full 24-pixel sequence repeats from row 0.
- K=7, WIDTH=8, HEIGHT=4 → ROW_LEN=14, NROWS=10, first 3 rows all zero, and oPixReady high only at cols 3..10 of rows 3..6.
